// File: rtl/alarm_bank_if.sv
// alarm_bank host bus: slot write, slot clear and registered slot readback.
interface alarm_bank_if #(
    parameter int IDX_W = 2
);
    logic             mode12;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             propagate;
    logic             in_PM;
    logic [4:0]       in_hours;
    logic [5:0]       in_minutes;
    logic             clr_en;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic             rd_isPM;
    logic [4:0]       rd_hours;
    logic [5:0]       rd_minutes;

    modport master (
        output mode12, wr_en, wr_idx, propagate, in_PM, in_hours, in_minutes,
        output clr_en, clr_idx, rd_idx,
        input  rd_valid, rd_isPM, rd_hours, rd_minutes
    );

    modport slave (
        input  mode12, wr_en, wr_idx, propagate, in_PM, in_hours, in_minutes,
        input  clr_en, clr_idx, rd_idx,
        output rd_valid, rd_isPM, rd_hours, rd_minutes
    );
endinterface

// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm store (24-hour internal form, hours 24 = empty)
// with a ring / snooze / dismiss controller driven by minute ticks.
module alarm_bank #(
    parameter int N_ALARMS       = 4,
    parameter int IDX_W          = 2,
    parameter int RING_MINUTES   = 5,
    parameter int SNOOZE_MINUTES = 9,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enabled,
    input  logic             tick_min,
    input  logic [4:0]       extern_hours,
    input  logic [5:0]       extern_minutes,
    input  logic             snooze,
    input  logic             dismiss,
    alarm_bank_if.slave      bus,
    output logic             ringing,
    output logic             snoozing,
    output logic [IDX_W-1:0] ring_idx
);
    localparam int TMAX = (RING_MINUTES > SNOOZE_MINUTES) ? RING_MINUTES : SNOOZE_MINUTES;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;
    localparam int SW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [4:0] EMPTY_H = 5'd24;

    typedef enum logic [1:0] {ST_IDLE, ST_RING, ST_SNOOZE} state_t;

    logic [4:0]       slot_h [N_ALARMS];
    logic [5:0]       slot_m [N_ALARMS];
    logic             wr_ok;
    logic [4:0]       wr_h;
    logic [5:0]       wr_m;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [4:0]       sel_h;
    logic [5:0]       sel_m;
    state_t           state, state_nx;
    logic [TW-1:0]    timer, timer_nx, timer_inc;
    logic [SW-1:0]    snz_cnt, snz_nx;
    logic [IDX_W-1:0] ring_idx_nx;
    logic             abort;

    // Validate the write request and convert it to internal 24-hour form.
    always_comb begin
        wr_ok = 1'b0;
        wr_h  = bus.in_hours;
        wr_m  = bus.in_minutes;
        if (bus.propagate) begin
            wr_ok = 1'b1;
            wr_h  = extern_hours;
            wr_m  = extern_minutes;
        end else if (bus.in_minutes <= 6'd59) begin
            if (bus.mode12) begin
                if (bus.in_hours >= 5'd1 && bus.in_hours <= 5'd12) begin
                    wr_ok = 1'b1;
                    if (bus.in_hours == 5'd12)
                        wr_h = bus.in_PM ? 5'd12 : 5'd0;
                    else
                        wr_h = bus.in_PM ? bus.in_hours + 5'd12 : bus.in_hours;
                end
            end else if (bus.in_hours <= 5'd23) begin
                wr_ok = 1'b1;
            end
        end
    end

    // Slot storage: clear beats a write to the same slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                slot_h[i] <= EMPTY_H;
                slot_m[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_ALARMS; i++) begin
                if (bus.clr_en && bus.clr_idx == IDX_W'(i)) begin
                    slot_h[i] <= EMPTY_H;
                    slot_m[i] <= '0;
                end else if (bus.wr_en && wr_ok && bus.wr_idx == IDX_W'(i)) begin
                    slot_h[i] <= wr_h;
                    slot_m[i] <= wr_m;
                end
            end
        end
    end

    // Find the lowest-index set slot equal to the live time.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            if (!hit && slot_h[i] != EMPTY_H && slot_h[i] == extern_hours &&
                slot_m[i] == extern_minutes) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Select the readback slot; indices past N_ALARMS read as empty.
    always_comb begin
        sel_h = EMPTY_H;
        sel_m = '0;
        for (int unsigned i = 0; i < N_ALARMS; i++) begin
            if (bus.rd_idx == IDX_W'(i)) begin
                sel_h = slot_h[i];
                sel_m = slot_m[i];
            end
        end
    end

    // Registered readback with optional 12-hour formatting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rd_valid   <= 1'b0;
            bus.rd_isPM    <= 1'b0;
            bus.rd_hours   <= EMPTY_H;
            bus.rd_minutes <= '0;
        end else if (sel_h >= EMPTY_H) begin
            bus.rd_valid   <= 1'b0;
            bus.rd_isPM    <= 1'b0;
            bus.rd_hours   <= EMPTY_H;
            bus.rd_minutes <= '0;
        end else begin
            bus.rd_valid   <= 1'b1;
            bus.rd_minutes <= sel_m;
            if (!bus.mode12) begin
                bus.rd_isPM  <= 1'b0;
                bus.rd_hours <= sel_h;
            end else if (sel_h == 5'd0) begin
                bus.rd_isPM  <= 1'b0;
                bus.rd_hours <= 5'd12;
            end else if (sel_h < 5'd12) begin
                bus.rd_isPM  <= 1'b0;
                bus.rd_hours <= sel_h;
            end else if (sel_h == 5'd12) begin
                bus.rd_isPM  <= 1'b1;
                bus.rd_hours <= 5'd12;
            end else begin
                bus.rd_isPM  <= 1'b1;
                bus.rd_hours <= sel_h - 5'd12;
            end
        end
    end

    assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
    assign abort     = dismiss || (bus.clr_en && bus.clr_idx == ring_idx);

    // Ring controller next state; dismiss/clear/disable override everything,
    // and an accepted snooze takes precedence over a same-cycle ring expiry.
    always_comb begin
        state_nx    = state;
        timer_nx    = timer;
        snz_nx      = snz_cnt;
        ring_idx_nx = ring_idx;
        case (state)
            ST_IDLE: begin
                if (enabled && tick_min && hit) begin
                    state_nx    = ST_RING;
                    ring_idx_nx = hit_idx;
                    timer_nx    = '0;
                    snz_nx      = '0;
                end
            end
            ST_RING: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (snooze && snz_cnt < SW'(MAX_SNOOZE)) begin
                    state_nx = ST_SNOOZE;
                    snz_nx   = snz_cnt + 1'b1;
                    timer_nx = '0;
                end else if (tick_min) begin
                    timer_nx = timer_inc;
                    if (timer_inc >= TW'(RING_MINUTES))
                        state_nx = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (tick_min) begin
                    timer_nx = timer_inc;
                    if (timer_inc >= TW'(SNOOZE_MINUTES)) begin
                        state_nx = ST_RING;
                        timer_nx = '0;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (!enabled)
            state_nx = ST_IDLE;
    end

    // Ring controller state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            snz_cnt  <= '0;
            ring_idx <= '0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            snz_cnt  <= snz_nx;
            ring_idx <= ring_idx_nx;
        end
    end

    assign ringing  = (state == ST_RING);
    assign snoozing = (state == ST_SNOOZE);
endmodule

// File: tb/tb_alarm_bank.sv
// Testbench for alarm_bank: directed scenarios then random traffic, all
// checked against a minute-of-day reference model through a scoreboard queue.
module tb_alarm_bank;
    localparam int RING_MIN   = 5;
    localparam int SNOOZE_MIN = 9;
    localparam int MAX_SNZ    = 3;

    typedef struct {
        bit v;
        bit pm;
        int h;
        int m;
        bit ring;
        bit snz;
        int ridx;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enabled;
    logic       tick_min;
    logic [4:0] extern_hours;
    logic [5:0] extern_minutes;
    logic       snooze;
    logic       dismiss;
    logic       ringing;
    logic       snoozing;
    logic [1:0] ring_idx;

    alarm_bank_if #(.IDX_W(2)) bus ();

    alarm_bank #(
        .N_ALARMS(4), .IDX_W(2), .RING_MINUTES(RING_MIN),
        .SNOOZE_MINUTES(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNZ)
    ) dut (
        .clk(clk), .reset(reset), .enabled(enabled), .tick_min(tick_min),
        .extern_hours(extern_hours), .extern_minutes(extern_minutes),
        .snooze(snooze), .dismiss(dismiss), .bus(bus),
        .ringing(ringing), .snoozing(snoozing), .ring_idx(ring_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each alarm is a minute-of-day, -1 when empty.
    int    tod [4];
    string phase;
    int    ring_slot;
    int    mins_left;
    int    snoozes_left;
    exp_t  sb [$];
    int    vectors;
    int    miscompares;

    task automatic model_step();
        exp_t e;
        int   hit, now, hh, val, wi, ci;
        bit   ok, abort;
        if (!reset) begin
            for (int i = 0; i < 4; i++) tod[i] = -1;
            phase = "IDLE"; ring_slot = 0; mins_left = 0; snoozes_left = 0;
            e = '{0, 0, 24, 0, 0, 0, 0};
            sb.push_back(e);
            return;
        end
        // readback reflects the slot contents before this edge
        if (tod[int'(bus.rd_idx)] < 0) begin
            e.v = 0; e.pm = 0; e.h = 24; e.m = 0;
        end else begin
            hh = tod[int'(bus.rd_idx)] / 60;
            e.v = 1;
            e.m = tod[int'(bus.rd_idx)] % 60;
            if (bus.mode12) begin
                e.pm = (hh >= 12);
                e.h  = (hh % 12 == 0) ? 12 : hh % 12;
            end else begin
                e.pm = 0;
                e.h  = hh;
            end
        end
        now = int'(extern_hours) * 60 + int'(extern_minutes);
        hit = -1;
        if (tick_min && enabled && phase == "IDLE")
            for (int i = 0; i < 4; i++)
                if (hit < 0 && tod[i] == now) hit = i;
        abort = dismiss || (bus.clr_en && int'(bus.clr_idx) == ring_slot);
        if (!enabled) begin
            phase = "IDLE";
        end else if (phase == "IDLE") begin
            if (hit >= 0) begin
                phase = "RING"; ring_slot = hit;
                mins_left = RING_MIN; snoozes_left = MAX_SNZ;
            end
        end else if (abort) begin
            phase = "IDLE";
        end else if (phase == "RING") begin
            if (snooze && snoozes_left > 0) begin
                phase = "SNOOZE"; mins_left = SNOOZE_MIN; snoozes_left--;
            end else if (tick_min) begin
                mins_left--;
                if (mins_left == 0) phase = "IDLE";
            end
        end else begin
            if (tick_min) begin
                mins_left--;
                if (mins_left == 0) begin
                    phase = "RING"; mins_left = RING_MIN;
                end
            end
        end
        // slot update
        wi = int'(bus.wr_idx);
        ci = int'(bus.clr_idx);
        ok = 0; val = 0;
        if (bus.propagate) begin
            ok = 1; val = now;
        end else if (bus.in_minutes <= 59) begin
            if (bus.mode12) begin
                if (bus.in_hours >= 1 && bus.in_hours <= 12) begin
                    ok = 1;
                    val = ((int'(bus.in_hours) % 12) + (bus.in_PM ? 12 : 0)) * 60 + int'(bus.in_minutes);
                end
            end else if (bus.in_hours <= 23) begin
                ok = 1;
                val = int'(bus.in_hours) * 60 + int'(bus.in_minutes);
            end
        end
        if (bus.wr_en && ok && !(bus.clr_en && ci == wi)) tod[wi] = val;
        if (bus.clr_en) tod[ci] = -1;
        e.ring = (phase == "RING");
        e.snz  = (phase == "SNOOZE");
        e.ridx = ring_slot;
        sb.push_back(e);
    endtask

    // Monitor: one output vector per cycle, sampled mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (bus.rd_valid !== e.v || bus.rd_isPM !== e.pm ||
                    int'(bus.rd_hours) != e.h || int'(bus.rd_minutes) != e.m ||
                    ringing !== e.ring || snoozing !== e.snz || int'(ring_idx) != e.ridx) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got v=%0b pm=%0b h=%0d m=%0d ring=%0b snz=%0b idx=%0d, want v=%0b pm=%0b h=%0d m=%0d ring=%0b snz=%0b idx=%0d",
                             vectors, $time, bus.rd_valid, bus.rd_isPM, bus.rd_hours, bus.rd_minutes,
                             ringing, snoozing, ring_idx, e.v, e.pm, e.h, e.m, e.ring, e.snz, e.ridx);
                end
            end
        end
    end

    task automatic quiet();
        bus.wr_en = 0; bus.clr_en = 0; bus.propagate = 0;
        tick_min = 0; snooze = 0; dismiss = 0;
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic set_ext(input int h, input int m);
        extern_hours = 5'(h); extern_minutes = 6'(m);
    endtask

    task automatic write_slot(input int idx, input bit m12, input int h, input int m, input bit pm);
        quiet();
        bus.mode12 = m12; bus.wr_en = 1; bus.wr_idx = 2'(idx);
        bus.in_hours = 5'(h); bus.in_minutes = 6'(m); bus.in_PM = pm;
        step();
        quiet();
    endtask

    task automatic read_slot(input int idx, input bit m12);
        quiet();
        bus.mode12 = m12; bus.rd_idx = 2'(idx);
        step();
        step();
    endtask

    task automatic ticks(input int n, input int h, input int m);
        for (int i = 0; i < n; i++) begin
            quiet(); set_ext(h, m); tick_min = 1; step();
            quiet(); step();
        end
    endtask

    int hpool [6];
    int mpool [6];

    initial begin
        int k;
        vectors = 0; miscompares = 0;
        hpool = '{6, 8, 13, 0, 19, 23};
        mpool = '{30, 0, 45, 5, 30, 59};
        reset = 0; enabled = 0;
        bus.mode12 = 0; bus.rd_idx = 0; bus.wr_idx = 0; bus.clr_idx = 0;
        bus.in_PM = 0; bus.in_hours = 0; bus.in_minutes = 0;
        quiet(); set_ext(0, 0);
        @(negedge clk);
        #2;
        repeat (3) step();
        reset = 1;
        for (int i = 0; i < 4; i++) read_slot(i, 0);
        enabled = 1;
        // 12-hour writes and both readback formats
        write_slot(1, 1, 12, 5, 0);
        read_slot(1, 0);
        write_slot(2, 1, 7, 30, 1);
        read_slot(2, 0);
        read_slot(2, 1);
        // basic ring and auto-off
        write_slot(0, 0, 6, 30, 0);
        ticks(1, 6, 30);
        ticks(5, 6, 31);
        // snooze three times, fourth ignored, then dismiss
        ticks(1, 6, 30);
        for (int r = 0; r < 4; r++) begin
            quiet(); snooze = 1; step();
            quiet(); step();
            if (r < 3) ticks(SNOOZE_MIN, 7, 0);
        end
        quiet(); dismiss = 1; step();
        // lowest index wins; dismiss beats snooze
        write_slot(1, 0, 8, 0, 0);
        write_slot(3, 0, 8, 0, 0);
        ticks(1, 8, 0);
        quiet(); dismiss = 1; snooze = 1; step();
        quiet(); step();
        // invalid writes leave the slot alone
        write_slot(1, 0, 24, 10, 0);
        read_slot(1, 0);
        write_slot(1, 1, 0, 10, 0);
        write_slot(1, 1, 13, 10, 1);
        write_slot(1, 0, 5, 60, 0);
        read_slot(1, 1);
        // clear beats write on the same slot
        quiet(); bus.clr_en = 1; bus.clr_idx = 2; bus.wr_en = 1; bus.wr_idx = 2;
        bus.mode12 = 0; bus.in_hours = 10; bus.in_minutes = 10; step();
        read_slot(2, 0);
        // propagate copies the live time verbatim
        quiet(); set_ext(13, 45); bus.wr_en = 1; bus.propagate = 1; bus.wr_idx = 3;
        bus.in_hours = 30; bus.in_minutes = 62; step();
        read_slot(3, 0);
        read_slot(3, 1);
        // clearing the ringing slot stops the alarm
        ticks(1, 6, 30);
        quiet(); bus.clr_en = 1; bus.clr_idx = 0; step();
        quiet(); step();
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            quiet();
            enabled     = ($urandom_range(0, 39) != 0);
            bus.mode12  = 1'($urandom_range(0, 1));
            bus.rd_idx  = 2'($urandom_range(0, 3));
            tick_min    = ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 6);
            if (k < 6) set_ext(hpool[k], mpool[k]);
            else set_ext($urandom_range(0, 23), $urandom_range(0, 59));
            if ($urandom_range(0, 6) == 0) begin
                bus.wr_en     = 1;
                bus.wr_idx    = 2'($urandom_range(0, 3));
                bus.propagate = ($urandom_range(0, 4) == 0);
                bus.in_PM     = 1'($urandom_range(0, 1));
                k = $urandom_range(0, 5);
                bus.in_hours   = ($urandom_range(0, 1) == 1) ? 5'(hpool[k]) : 5'($urandom_range(0, 25));
                bus.in_minutes = ($urandom_range(0, 9) != 0) ? 6'(mpool[k]) : 6'($urandom_range(0, 63));
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.clr_en  = 1;
                bus.clr_idx = 2'($urandom_range(0, 3));
            end
            snooze  = ($urandom_range(0, 7) == 0);
            dismiss = ($urandom_range(0, 39) == 0);
            step();
        end
        quiet();
        repeat (2) @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-slot alarm store and ring controller for the clock system.
- Holds N_ALARMS alarm times internally in 24-hour form. Hours value 24 marks an empty slot.
- Accepts writes in 12-hour or 24-hour format, or copies the live clock time into a slot.
- Compares the slots against the live time on each minute tick and runs a ring/snooze/dismiss state machine that drives the buzzer logic.

Parameters:
- N_ALARMS, 4, number of alarm slots.
- IDX_W, 2, slot index width; must satisfy 2**IDX_W >= N_ALARMS.
- RING_MINUTES, 5, minute ticks of ringing before auto-off.
- SNOOZE_MINUTES, 9, minute ticks spent in snooze before re-ringing.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enabled  in  1  global alarm enable.
- tick_min  in  1  one-cycle pulse; the extern time has just advanced to a new minute.
- extern_hours  in  5  live time hours, 0-23.
- extern_minutes  in  6  live time minutes, 0-59.
- mode12  in  1  1 = writes and readback use 12-hour format.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_W  target slot for the write.
- propagate  in  1  with wr_en, load the slot from extern time instead of the in_* inputs.
- in_PM  in  1  PM flag; used in 12-hour mode only.
- in_hours  in  5  12-hour mode: 1-12; 24-hour mode: 0-23.
- in_minutes  in  6  0-59.
- clr_en  in  1  clear strobe.
- clr_idx  in  IDX_W  slot to clear.
- snooze  in  1  one-cycle snooze request.
- dismiss  in  1  one-cycle dismiss request.
- rd_idx  in  IDX_W  readback slot select.
- rd_valid  out  1  selected slot is set.
- rd_isPM  out  1  readback PM flag (12-hour mode).
- rd_hours  out  5  readback hours.
- rd_minutes  out  6  readback minutes.
- ringing  out  1  FSM is in RING.
- snoozing  out  1  FSM is in SNOOZE.
- ring_idx  out  IDX_W  slot that triggered the current event.

Behaviour:
- Reset (reset low, asynchronous):
  - Every slot: hours = 24, minutes = 0.
  - FSM to IDLE; minute timer and snooze count to 0.
  - All outputs 0, except rd_hours = 24.
- Write (wr_en=1), takes effect on the next edge:
  - 12-hour to internal conversion: 12 AM -> 0; 12 PM -> 12; h PM with h < 12 -> h+12; h AM -> h.
  - Invalid input is ignored and the slot is unchanged. Invalid means minutes > 59, 24-hour hours > 23, or 12-hour hours of 0 or above 12.
  - With propagate=1, extern_hours/extern_minutes are stored directly, with no format conversion.
  - Writes are accepted regardless of enabled.
  - Writing the ringing slot does not disturb the FSM.
- Clear (clr_en=1): slot hours = 24, minutes = 0. If clear and write hit the same slot in the same cycle, clear wins.
- Readback: registered, 1-cycle latency from rd_idx.
  - Empty slot: rd_valid = 0, rd_hours = 24, rd_isPM = 0, rd_minutes = 0.
  - mode12 = 1: internal 0 -> 12 AM; 1-11 -> AM; 12 -> 12 PM; 13-23 -> h-12 PM.
  - mode12 = 0: internal hours returned, rd_isPM = 0.
- Match: evaluated only on tick_min, with enabled=1 and FSM in IDLE.
  - Every set slot is compared against extern time in that same cycle.
  - If several slots match, the lowest index wins.
  - Next cycle: FSM enters RING, ring_idx is latched, timer = 0, snooze count = 0.
  - Matches that occur during RING or SNOOZE are dropped.
- FSM states:
  - IDLE: waits for a match.
  - RING: each tick_min increments the timer. When the timer reaches RING_MINUTES, go to IDLE. On snooze with count < MAX_SNOOZE, go to SNOOZE, count += 1, timer = 0. A snooze when count = MAX_SNOOZE is ignored.
  - SNOOZE: each tick_min increments the timer. When the timer reaches SNOOZE_MINUTES, go to RING with timer = 0.
  - dismiss in RING or SNOOZE goes to IDLE on the next edge. dismiss has priority over snooze and over timer expiry in the same cycle.
  - Clearing slot ring_idx while in RING or SNOOZE goes to IDLE.
  - enabled = 0 forces IDLE on the next edge.
- Timer width: ceil(log2(max(RING_MINUTES, SNOOZE_MINUTES)+1)) bits. The timer never wraps.

Test Plan:
- Reset, then read every slot -> rd_valid = 0, rd_hours = 24, and ringing = 0 throughout.
- mode12 = 1: write slot 1 as 12 AM 5 min -> 24-hour readback gives hours 0, minutes 5. Write slot 2 as 7 PM 30 min -> 24-hour readback gives hours 19; 12-hour readback gives 7 PM.
- Slot 0 set to 6:30; pulse tick_min with extern 6:30 -> ringing = 1 and ring_idx = 0 one cycle later. After 5 more ticks -> ringing = 0.
- While ringing, assert snooze -> snoozing = 1. After 9 ticks -> ringing = 1. Repeat 3 times; the 4th snooze is ignored and ringing stays 1.
- Slots 1 and 3 both set to 8:00; tick at 8:00 -> ring_idx = 1. dismiss and snooze asserted together -> IDLE.
- Write 24-hour hours 24, and 12-hour hours 0 -> slot unchanged. Clear and write slot 2 in the same cycle -> slot 2 empty. propagate write with extern 13:45 -> readback 13:45.
